axi_lite_read_arbiter: RTL and testbench
========================================

# axi_lite_read_arbiter

Shares one AXI-Lite master read channel (AR + R) among `NUM_REQ` internal requesters using round-robin arbitration with one outstanding transaction. It sits upstream of the AXI-Lite slave read interface and drives its ARADDR/ARVALID and RREADY. It returns each read's data and response to the granted requester through a per-requester valid/ready response handshake.

## Interface
- `REG_WIDTH`, 32: address and data width.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ACLK`  in  1  clock; all logic on rising edge.
- `ARESET`  in  1  synchronous, active-high reset.
- `REQ_VALID`  in  NUM_REQ  per-requester read request.
- `REQ_ADDR`  in  NUM_REQ*REG_WIDTH  packed addresses; requester i at bits [i*REG_WIDTH +: REG_WIDTH].
- `REQ_READY`  out  NUM_REQ  one-hot request accept (combinational).
- `RSP_VALID`  out  NUM_REQ  one-hot response valid (registered).
- `RSP_READY`  in  NUM_REQ  per-requester response accept.
- `RSP_DATA`  out  REG_WIDTH  shared response data.
- `RSP_RESP`  out  2  shared AXI response code.
- `ARADDR`  out  REG_WIDTH  master read address.
- `ARVALID`  out  1  master read address valid.
- `ARREADY`  in  1  slave address accept.
- `RDATA`  in  REG_WIDTH  slave read data.
- `RRESP`  in  2  slave read response.
- `RVALID`  in  1  slave data valid.
- `RREADY`  out  1  master data accept.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any REQ_VALID, pick winner g by round-robin, searching from (ptr+1) mod NUM_REQ upward with wrap. REQ_READY[g]=1 that cycle. Latch REQ_ADDR[g] into ARADDR and g into grant register. Go to ADDR. No request: stay, all outputs low.
- ADDR: ARVALID=1, ARADDR stable. On ARREADY go to DATA.
- DATA: RREADY=1. On RVALID capture RDATA→RSP_DATA and RRESP→RSP_RESP, then go to RESP.
- RESP: RSP_VALID[g]=1, data/resp stable. On RSP_READY[g], set ptr<=g and go to IDLE.
- REQ_READY is zero outside IDLE. RSP_READY of non-granted requesters is ignored.
- Requesters whose REQ_VALID drops before grant are never served. REQ_ADDR after accept is don't-care.
- Non-OKAY RRESP is passed through unmodified; no retry.

## Timing
- Reset values: ARVALID=0, RREADY=0, ARADDR=0, RSP_VALID=0, RSP_DATA=0, RSP_RESP=0, state=IDLE, grant=0, ptr=NUM_REQ-1 (so requester 0 wins first).
- Minimum latency with an always-ready slave: accept at cycle 0, ARVALID cycle 1, RREADY cycle 2, RVALID sampled cycle 2, RSP_VALID cycle 3, next accept cycle 4 if RSP_READY is high at cycle 3.
- ARVALID stays asserted until ARREADY, with no deassertion. RREADY is asserted only in DATA.
- RVALID seen in IDLE/ADDR/RESP is ignored (protocol violation upstream).
- All requesters continuously valid: grants rotate 0,1,2,3,0,… Single requester: served back-to-back.
- Reset asserted mid-transaction: next edge returns to the reset state. In-flight AXI transaction is abandoned; the slave shares the same reset domain.

## Structure
- Shared package: FSM state enum (2-bit), AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: request vector and ptr. Outputs: one-hot grant and binary index. Reusable for the write-channel arbiter.

## Test plan
- Reset: hold ARESET 3 cycles with REQ_VALID=4'b1111 → all outputs 0, no REQ_READY. After release, first grant is REQ_READY=4'b0001.
- Single read: requester 2, addr 0x0000_0010, slave ARREADY after 2 cycles, RDATA=0xDEAD_BEEF, RRESP=OKAY → ARADDR=0x10 held until ARREADY, RSP_VALID=4'b0100, RSP_DATA=0xDEADBEEF.
- Fairness: REQ_VALID=4'b1111 for 8 transactions → grant order 0,1,2,3,0,1,2,3. Then REQ_VALID=4'b1010 → order 1,3,1,3.
- Response backpressure: RSP_READY[g]=0 for 5 cycles → RSP_VALID/RSP_DATA stable, no new REQ_READY, RREADY=0.
- Error passthrough: RRESP=SLVERR, RDATA=0x0 → RSP_RESP=2'b10 to the granted requester. The next request is then served normally.
- Reset mid-DATA state → ARVALID/RREADY/RSP_VALID 0 next cycle, ptr=NUM_REQ-1.

Source files
------------

// File: rtl/axi_lite_read_arbiter_pkg.sv
// rtl/axi_lite_read_arbiter_pkg.sv - shared types and constants for the AXI-Lite read arbiter
package axi_lite_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_read_arbiter_if.sv
// rtl/axi_lite_read_arbiter_if.sv - requester and AXI-Lite read channel bundle
interface axi_lite_read_arbiter_if #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           REQ_VALID;
    logic [NUM_REQ*REG_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]           REQ_READY;
    logic [NUM_REQ-1:0]           RSP_VALID;
    logic [NUM_REQ-1:0]           RSP_READY;
    logic [REG_WIDTH-1:0]         RSP_DATA;
    logic [1:0]                   RSP_RESP;
    logic [REG_WIDTH-1:0]         ARADDR;
    logic                         ARVALID;
    logic                         ARREADY;
    logic [REG_WIDTH-1:0]         RDATA;
    logic [1:0]                   RRESP;
    logic                         RVALID;
    logic                         RREADY;

    // master: the arbiter itself; slave: requesters plus AXI-Lite slave
    modport master (
        input  REQ_VALID, REQ_ADDR, RSP_READY, ARREADY, RDATA, RRESP, RVALID,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_RESP, ARADDR, ARVALID, RREADY
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, RSP_READY, ARREADY, RDATA, RRESP, RVALID,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_RESP, ARADDR, ARVALID, RREADY
    );

endinterface

// File: rtl/axi_lite_read_arbiter_rr_pick.sv
// rtl/axi_lite_read_arbiter_rr_pick.sv - combinational round-robin picker
module axi_lite_read_arbiter_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin : pick
        int j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Walk from lowest to highest priority so the nearest requester after ptr wins last
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// rtl/axi_lite_read_arbiter.sv - round-robin sharing of one AXI-Lite read channel
module axi_lite_read_arbiter
    import axi_lite_read_arbiter_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REQ   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_lite_read_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [REG_WIDTH-1:0] araddr_q, araddr_d;
    logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;

    axi_lite_read_arbiter_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i   (bus.REQ_VALID),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        araddr_d   = araddr_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    req_ready = pick_gnt;
                    grant_d   = pick_idx;
                    araddr_d  = bus.REQ_ADDR[int'(pick_idx)*REG_WIDTH +: REG_WIDTH];
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.ARREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bus.RVALID) begin
                    rsp_data_d = bus.RDATA;
                    rsp_resp_d = bus.RRESP;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                // Pointer only advances once the winner has taken its response
                if (bus.RSP_READY[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= IW'(NUM_REQ - 1);
            araddr_q   <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= RESP_OKAY;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            araddr_q   <= araddr_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
        end
    end

    assign bus.REQ_READY = ARESET ? '0 : req_ready;
    assign bus.ARVALID   = (state_q == ST_ADDR);
    assign bus.ARADDR    = araddr_q;
    assign bus.RREADY    = (state_q == ST_DATA);
    assign bus.RSP_VALID = (state_q == ST_RESP) ? grant_oh : '0;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.RSP_RESP  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// tb/tb_axi_lite_read_arbiter.sv - self-checking bench for axi_lite_read_arbiter
module tb_axi_lite_read_arbiter;
    import axi_lite_read_arbiter_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mptr     = N - 1;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic [W-1:0] addr_tab [N];

    axi_lite_read_arbiter_if #(.REG_WIDTH(W), .NUM_REQ(N)) bus ();

    axi_lite_read_arbiter #(.REG_WIDTH(W), .NUM_REQ(N)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0 && i < N) v[i] = 1'b1;
        return v;
    endfunction

    task automatic scramble_addr();
        for (int i = 0; i < N; i++) bus.REQ_ADDR[i*W +: W] = $urandom;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.REQ_VALID = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_checks++; if (bus.REQ_READY !== '0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", bus.REQ_READY); end
            n_checks++; if (bus.ARVALID !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b expected 0", bus.ARVALID); end
            n_checks++; if (bus.RREADY !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b expected 0", bus.RREADY); end
            n_checks++; if (bus.ARADDR !== '0) begin n_fail++; $display("FAIL rst_araddr: got %h expected 0", bus.ARADDR); end
            n_checks++; if (bus.RSP_VALID !== '0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.RSP_VALID); end
            n_checks++; if (bus.RSP_DATA !== '0) begin n_fail++; $display("FAIL rst_rsp_data: got %h expected 0", bus.RSP_DATA); end
            n_checks++; if (bus.RSP_RESP !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_resp: got %b expected 00", bus.RSP_RESP); end
        end
        rst = 1'b0;
        bus.REQ_VALID = '0;
        mptr = N - 1;
    endtask

    // One full read; starts just after a negedge with the arbiter idle and ends the same way
    task automatic do_txn(input logic [N-1:0] mask, input int ar_dly, input int r_dly,
                          input logic [W-1:0] rdata, input logic [1:0] rresp, input int rsp_dly,
                          output int g_obs);
        int g_exp;
        int j;
        logic [W-1:0] addr_exp;
        g_exp = -1;
        for (int k = 1; k <= N; k++) begin
            j = (mptr + k) % N;
            if (g_exp < 0 && mask[j]) g_exp = j;
        end
        addr_exp = (g_exp >= 0) ? addr_tab[g_exp] : '0;
        for (int i = 0; i < N; i++) bus.REQ_ADDR[i*W +: W] = addr_tab[i];
        bus.REQ_VALID = mask;
        bus.RSP_READY = '0;
        #1;
        acc_cyc = cyc;
        n_checks++; if (bus.REQ_READY !== oh(g_exp)) begin n_fail++; $display("FAIL grant: got %b expected %b", bus.REQ_READY, oh(g_exp)); end
        g_obs = -1;
        for (int i = 0; i < N; i++) if (bus.REQ_READY[i] === 1'b1) g_obs = i;
        @(negedge clk);
        bus.REQ_VALID = '0;
        scramble_addr();
        for (int c = 0; c <= ar_dly; c++) begin
            bus.ARREADY = (c == ar_dly);
            bus.RVALID  = 1'b1;
            bus.RDATA   = ~rdata;
            bus.RRESP   = ~rresp;
            #1;
            n_checks++; if (bus.ARVALID !== 1'b1) begin n_fail++; $display("FAIL addr_arvalid: got %b expected 1", bus.ARVALID); end
            n_checks++; if (bus.ARADDR !== addr_exp) begin n_fail++; $display("FAIL addr_araddr: got %h expected %h", bus.ARADDR, addr_exp); end
            n_checks++; if (bus.RREADY !== 1'b0) begin n_fail++; $display("FAIL addr_rready: got %b expected 0", bus.RREADY); end
            @(negedge clk);
        end
        bus.ARREADY = 1'b0;
        for (int c = 0; c <= r_dly; c++) begin
            bus.RVALID = (c == r_dly);
            bus.RDATA  = (c == r_dly) ? rdata : $urandom;
            bus.RRESP  = (c == r_dly) ? rresp : 2'($urandom);
            #1;
            n_checks++; if (bus.RREADY !== 1'b1) begin n_fail++; $display("FAIL data_rready: got %b expected 1", bus.RREADY); end
            n_checks++; if (bus.ARVALID !== 1'b0) begin n_fail++; $display("FAIL data_arvalid: got %b expected 0", bus.ARVALID); end
            n_checks++; if (bus.RSP_VALID !== '0) begin n_fail++; $display("FAIL data_rsp_valid: got %b expected 0", bus.RSP_VALID); end
            @(negedge clk);
        end
        bus.RVALID = 1'b1;
        bus.RDATA  = ~rdata;
        bus.RRESP  = ~rresp;
        bus.REQ_VALID = '1;
        for (int c = 0; c <= rsp_dly; c++) begin
            bus.RSP_READY = (c == rsp_dly) ? oh(g_exp) : ~oh(g_exp);
            #1;
            n_checks++; if (bus.RSP_VALID !== oh(g_exp)) begin n_fail++; $display("FAIL rsp_valid: got %b expected %b", bus.RSP_VALID, oh(g_exp)); end
            n_checks++; if (bus.RSP_DATA !== rdata) begin n_fail++; $display("FAIL rsp_data: got %h expected %h", bus.RSP_DATA, rdata); end
            n_checks++; if (bus.RSP_RESP !== rresp) begin n_fail++; $display("FAIL rsp_resp: got %b expected %b", bus.RSP_RESP, rresp); end
            n_checks++; if (bus.RREADY !== 1'b0) begin n_fail++; $display("FAIL rsp_rready: got %b expected 0", bus.RREADY); end
            n_checks++; if (bus.REQ_READY !== '0) begin n_fail++; $display("FAIL rsp_req_ready: got %b expected 0", bus.REQ_READY); end
            @(negedge clk);
        end
        bus.RSP_READY = '0;
        bus.REQ_VALID = '0;
        bus.RVALID    = 1'b0;
        if (g_exp >= 0) mptr = g_exp;
        #1;
        n_checks++; if (bus.RSP_VALID !== '0) begin n_fail++; $display("FAIL idle_rsp_valid: got %b expected 0", bus.RSP_VALID); end
    endtask

    task automatic test_reset();
        int g;
        apply_reset();
        for (int i = 0; i < N; i++) addr_tab[i] = 32'h1000 + 32'(i) * 4;
        do_txn('1, 0, 0, 32'h0000_0A0A, RESP_OKAY, 0, g);
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL first_grant: got %0d expected 0", g); end
    endtask

    task automatic test_idle();
        bus.REQ_VALID = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_checks++; if ({bus.ARVALID, bus.RREADY, bus.RSP_VALID, bus.REQ_READY} !== '0) begin
                n_fail++; $display("FAIL idle_outputs: got %b/%b/%b/%b expected all 0", bus.ARVALID, bus.RREADY, bus.RSP_VALID, bus.REQ_READY);
            end
        end
    endtask

    task automatic test_fairness();
        int g;
        apply_reset();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) addr_tab[i] = $urandom;
            do_txn(4'b1111, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, RESP_OKAY, $urandom_range(0, 1), g);
            n_checks++; if (g !== t % 4) begin n_fail++; $display("FAIL fair_all: got %0d expected %0d", g, t % 4); end
        end
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) addr_tab[i] = $urandom;
            do_txn(4'b1010, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, RESP_OKAY, 0, g);
            n_checks++; if (g !== ((t % 2) ? 3 : 1)) begin n_fail++; $display("FAIL fair_1010: got %0d expected %0d", g, (t % 2) ? 3 : 1); end
        end
    endtask

    task automatic test_single_read();
        int g;
        addr_tab[2] = 32'h0000_0010;
        do_txn(4'b0100, 2, 0, 32'hDEAD_BEEF, RESP_OKAY, 0, g);
        n_checks++; if (g !== 2) begin n_fail++; $display("FAIL single_grant: got %0d expected 2", g); end
    endtask

    task automatic test_backpressure();
        int g;
        addr_tab[0] = 32'h0000_0200;
        do_txn(4'b0001, 0, 1, 32'h1234_5678, RESP_EXOKAY, 5, g);
    endtask

    task automatic test_error();
        int g;
        addr_tab[3] = 32'h0000_0FF0;
        do_txn(4'b1000, 1, 1, 32'h0, RESP_SLVERR, 0, g);
        addr_tab[1] = 32'h0000_0044;
        do_txn(4'b0010, 0, 0, 32'hCAFE_F00D, RESP_OKAY, 0, g);
        n_checks++; if (g !== 1) begin n_fail++; $display("FAIL after_err_grant: got %0d expected 1", g); end
    endtask

    task automatic test_back_to_back();
        int g;
        int c0;
        addr_tab[1] = 32'h0000_0300;
        do_txn(4'b0010, 0, 0, $urandom, RESP_OKAY, 0, g);
        c0 = acc_cyc;
        do_txn(4'b0010, 0, 0, $urandom, RESP_OKAY, 0, g);
        n_checks++; if (acc_cyc - c0 !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 4", acc_cyc - c0); end
        n_checks++; if (g !== 1) begin n_fail++; $display("FAIL b2b_grant: got %0d expected 1", g); end
    endtask

    task automatic test_random();
        int g;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) addr_tab[i] = $urandom;
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), g);
        end
    endtask

    task automatic test_mid_reset();
        int g;
        addr_tab[0] = 32'h0000_0500;
        do_txn(4'b0001, 0, 0, $urandom, RESP_OKAY, 0, g);
        bus.REQ_VALID = '1;
        #1;
        n_checks++; if (bus.REQ_READY !== 4'b0010) begin n_fail++; $display("FAIL mid_grant: got %b expected 0010", bus.REQ_READY); end
        @(negedge clk);
        bus.REQ_VALID = '0;
        bus.ARREADY   = 1'b1;
        @(negedge clk);
        bus.ARREADY = 1'b0;
        #1;
        n_checks++; if (bus.RREADY !== 1'b1) begin n_fail++; $display("FAIL mid_in_data: got %b expected 1", bus.RREADY); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if ({bus.ARVALID, bus.RREADY, bus.RSP_VALID} !== '0) begin
            n_fail++; $display("FAIL mid_rst_outputs: got %b/%b/%b expected 0", bus.ARVALID, bus.RREADY, bus.RSP_VALID);
        end
        n_checks++; if (bus.ARADDR !== '0) begin n_fail++; $display("FAIL mid_rst_araddr: got %h expected 0", bus.ARADDR); end
        rst = 1'b0;
        mptr = N - 1;
        bus.REQ_VALID = '1;
        #1;
        n_checks++; if (bus.REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_ptr: got %b expected 0001", bus.REQ_READY); end
        @(negedge clk);
        bus.REQ_VALID = '0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_ADDR  = '0;
        bus.RSP_READY = '0;
        bus.ARREADY   = 1'b0;
        bus.RDATA     = '0;
        bus.RRESP     = 2'b00;
        bus.RVALID    = 1'b0;
        test_reset();
        test_idle();
        test_fairness();
        test_single_read();
        test_backpressure();
        test_error();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
